// File: rtl/spm_banked_mem_ctrl.sv
// Banked scratchpad memory controller with per-bank sleep/wake power states.
// Optional perf counters are enabled by defining SPM_BANKED_PERF_CNT_EN.
module spm_banked_mem_ctrl #(
  parameter int unsigned NumWords   = 1024,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned ByteWidth  = 8,
  parameter int unsigned NumBanks   = 4,
  parameter int unsigned Latency    = 1,
  parameter int unsigned WakeCycles = 4,
  parameter int unsigned IdleCycles = 0,
  localparam int unsigned WordW     = $clog2(NumWords),
  localparam int unsigned BankW     = $clog2(NumBanks),
  localparam int unsigned AddrW     = BankW + WordW,
  localparam int unsigned BeW       = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrW-1:0]     req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeW-1:0]       req_be_i,
  output logic                 rsp_valid_o,
  output logic [DataWidth-1:0] rsp_rdata_o,
  input  logic [NumBanks-1:0]  sleep_req_i,
  output logic [NumBanks-1:0]  bank_awake_o
`ifdef SPM_BANKED_PERF_CNT_EN
  ,
  output logic [31:0]          perf_access_o,
  output logic [31:0]          perf_stall_o
`endif
);

  localparam int unsigned BankIdxW = (NumBanks > 1) ? BankW : 1;
  localparam int unsigned IdleW    = (IdleCycles > 0) ? $clog2(IdleCycles + 1) : 1;
  localparam int unsigned WakeW    = $clog2(WakeCycles + 1);

  typedef enum logic [1:0] {StAwake, StSleep, StWaking} bank_state_e;

  bank_state_e          state_q [NumBanks];
  logic [IdleW-1:0]     idle_q  [NumBanks];
  logic [WakeW-1:0]     wake_q  [NumBanks];

  logic [Latency-1:0]   vld_q;
  logic [BankIdxW-1:0]  rbank_q [Latency];
  logic [DataWidth-1:0] rdata_q [Latency];

  logic [DataWidth-1:0] mem [NumBanks * NumWords];

  logic [BankIdxW-1:0]  req_bank;
  logic [NumBanks-1:0]  awake, target, hs_bank, inflight, idle_hit;
  logic                 hs;
  logic [DataWidth-1:0] wmask;

  // {bank, word} with power-of-two sizes is also the flat memory index.
  assign req_bank    = BankIdxW'(req_addr_i >> WordW);
  assign req_ready_o = awake[req_bank];
  assign hs          = req_valid_i && req_ready_o;

  always_comb begin
    awake    = '0;
    target   = '0;
    hs_bank  = '0;
    inflight = '0;
    idle_hit = '0;
    for (int b = 0; b < NumBanks; b++) begin
      awake[b]    = (state_q[b] == StAwake);
      target[b]   = req_valid_i && (req_bank == BankIdxW'(b));
      hs_bank[b]  = target[b] && awake[b];
      idle_hit[b] = (IdleCycles != 0) && (idle_q[b] == IdleW'(IdleCycles));
      for (int i = 0; i < Latency; i++) begin
        if (vld_q[i] && (rbank_q[i] == BankIdxW'(b))) inflight[b] = 1'b1;
      end
    end
  end

  assign bank_awake_o = awake;

  always_comb begin
    wmask = '0;
    for (int i = 0; i < DataWidth; i++) wmask[i] = req_be_i[i / ByteWidth];
  end

  always_ff @(posedge clk_i) begin
    if (hs && req_we_i) begin
      mem[req_addr_i] <= (mem[req_addr_i] & ~wmask) | (req_wdata_i & wmask);
    end
  end

  // Per-bank power FSM; a handshake or an in-flight read always blocks sleep.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < NumBanks; b++) begin
        state_q[b] <= StAwake;
        idle_q[b]  <= '0;
        wake_q[b]  <= '0;
      end
    end else begin
      for (int b = 0; b < NumBanks; b++) begin
        case (state_q[b])
          StAwake: begin
            if (!hs_bank[b] && !inflight[b] && (sleep_req_i[b] || idle_hit[b])) begin
              state_q[b] <= StSleep;
              idle_q[b]  <= '0;
            end else if (hs_bank[b]) begin
              idle_q[b] <= '0;
            end else if (idle_q[b] != IdleW'(IdleCycles)) begin
              idle_q[b] <= idle_q[b] + 1'b1;
            end
          end
          StSleep: begin
            if (!sleep_req_i[b] && target[b]) begin
              state_q[b] <= StWaking;
              wake_q[b]  <= '0;
            end
          end
          StWaking: begin
            if (wake_q[b] == WakeW'(WakeCycles - 1)) begin
              state_q[b] <= StAwake;
              wake_q[b]  <= '0;
            end else begin
              wake_q[b] <= wake_q[b] + 1'b1;
            end
          end
          default: state_q[b] <= StAwake;
        endcase
      end
    end
  end

  // Read pipeline; data stages only advance with a valid so the output holds.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < Latency; i++) begin
        rbank_q[i] <= '0;
        rdata_q[i] <= '0;
      end
    end else begin
      vld_q[0]   <= hs && !req_we_i;
      rbank_q[0] <= req_bank;
      if (hs && !req_we_i) rdata_q[0] <= mem[req_addr_i];
      for (int i = 1; i < Latency; i++) begin
        vld_q[i]   <= vld_q[i-1];
        rbank_q[i] <= rbank_q[i-1];
        if (vld_q[i-1]) rdata_q[i] <= rdata_q[i-1];
      end
    end
  end

  assign rsp_valid_o = vld_q[Latency-1];
  assign rsp_rdata_o = rdata_q[Latency-1];

`ifdef SPM_BANKED_PERF_CNT_EN
  logic [31:0] perf_access_q, perf_stall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_access_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (hs) perf_access_q <= perf_access_q + 32'd1;
      if (req_valid_i && !req_ready_o) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_access_o = perf_access_q;
  assign perf_stall_o  = perf_stall_q;
`else
  // No counter state in the default build.
`endif

endmodule

// File: tb/tb_spm_banked_mem_ctrl.sv
// Scoreboard bench for spm_banked_mem_ctrl: Latency=2, WakeCycles=4, IdleCycles=3.
module tb_spm_banked_mem_ctrl;

  localparam int unsigned NumWords = 16;
  localparam int unsigned NumBanks = 4;
  localparam int unsigned Lat      = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [5:0]  req_addr_i = '0;
  logic [63:0] req_wdata_i = '0;
  logic [7:0]  req_be_i = '0;
  logic        rsp_valid_o;
  logic [63:0] rsp_rdata_o;
  logic [3:0]  sleep_req_i = '0;
  logic [3:0]  bank_awake_o;
`ifdef SPM_BANKED_PERF_CNT_EN
  logic [31:0] perf_access, perf_stall;
`endif

  spm_banked_mem_ctrl #(
    .NumWords  (NumWords),
    .DataWidth (64),
    .ByteWidth (8),
    .NumBanks  (NumBanks),
    .Latency   (Lat),
    .WakeCycles(4),
    .IdleCycles(3)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_be_i    (req_be_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .sleep_req_i (sleep_req_i),
    .bank_awake_o(bank_awake_o)
`ifdef SPM_BANKED_PERF_CNT_EN
    ,
    .perf_access_o(perf_access),
    .perf_stall_o (perf_stall)
`endif
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [63:0] model [64];
  logic [63:0] last_exp = '0;
  int          checks = 0;
  int          errors = 0;
  int          st;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_i) begin
      last_exp = '0;
    end else if (rsp_valid_o) begin
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", 64'(rsp_valid_o), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("rsp_data", rsp_rdata_o, e.data);
        check_eq("rsp_cycle", 64'(cyc), 64'(e.cyc));
        last_exp = e.data;
      end
    end else begin
      check_eq("rsp_hold", rsp_rdata_o, last_exp);
    end
  end

  // Called at a negedge; returns at the negedge after the handshake.
  task automatic do_req(input logic we, input logic [5:0] addr, input logic [63:0] wdata,
                        input logic [7:0] be, output int stalls);
    exp_t x;
    stalls      = 0;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_be_i    = be;
    #1;
    while (!req_ready_o && stalls < 30) begin
      stalls++;
      @(negedge clk_i);
      #1;
    end
    if (!req_ready_o) begin
      check_eq("req_timeout", 64'(req_ready_o), 64'd1);
    end else if (we) begin
      for (int i = 0; i < 8; i++) if (be[i]) model[addr][i*8 +: 8] = wdata[i*8 +: 8];
    end else begin
      x.data = model[addr];
      x.cyc  = cyc + Lat;
      exp_q.push_back(x);
    end
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    #1;
    check_eq("rst_awake", 64'(bank_awake_o), 64'hF);
    check_eq("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check_eq("rst_rdata", rsp_rdata_o, 64'd0);
`ifdef SPM_BANKED_PERF_CNT_EN
    check_eq("rst_perf_access", 64'(perf_access), 64'd0);
    check_eq("rst_perf_stall", 64'(perf_stall), 64'd0);
`endif
    @(negedge clk_i);
    rst_i = 1'b0;

    // Write then read back-to-back; latency is checked by the scoreboard.
    do_req(1'b1, {2'd1, 4'd5}, 64'hDEADBEEF_00000001, 8'hFF, st);
    do_req(1'b0, {2'd1, 4'd5}, '0, '0, st);

    // Partial byte enable over zero.
    do_req(1'b1, {2'd0, 4'd3}, 64'h0, 8'hFF, st);
    do_req(1'b1, {2'd0, 4'd3}, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, st);
    do_req(1'b0, {2'd0, 4'd3}, '0, '0, st);

    do_req(1'b1, {2'd3, 4'd7}, 64'h0123_4567_89AB_CDEF, 8'hFF, st);
    do_req(1'b1, {2'd3, 4'd7}, 64'hFFFF_FFFF_FFFF_FFFF, 8'hA5, st);
    do_req(1'b0, {2'd1, 4'd5}, '0, '0, st);
    do_req(1'b0, {2'd3, 4'd7}, '0, '0, st);
    do_req(1'b0, {2'd0, 4'd3}, '0, '0, st);
    repeat (4) @(negedge clk_i);

    // Forced sleep, then wake-up through a request.
    do_req(1'b1, {2'd2, 4'd9}, 64'hCAFE_F00D_1234_5678, 8'hFF, st);
    sleep_req_i = 4'b0100;
    @(negedge clk_i);
    #1;
    check_eq("sleep_bank2", 64'(bank_awake_o[2]), 64'd0);
    @(negedge clk_i);
    sleep_req_i = 4'b0000;
    do_req(1'b0, {2'd2, 4'd9}, '0, '0, st);
    check_eq("wake_stalls", 64'(st), 64'd5);
    repeat (4) @(negedge clk_i);

    // Auto-sleep after 3 idle cycles; an access in idle cycle 2 restarts it.
    do_req(1'b1, {2'd0, 4'd1}, 64'h1111_2222_3333_4444, 8'hFF, st);
    repeat (2) @(negedge clk_i);
    do_req(1'b1, {2'd0, 4'd2}, 64'h5555_6666_7777_8888, 8'hFF, st);
    check_eq("idle_restart_ready", 64'(st), 64'd0);
    repeat (3) @(negedge clk_i);
    #1;
    check_eq("idle_awake_3", 64'(bank_awake_o[0]), 64'd1);
    @(negedge clk_i);
    #1;
    check_eq("idle_sleep_4", 64'(bank_awake_o[0]), 64'd0);

    // Sleep request coincident with a read handshake.
    @(negedge clk_i);
    do_req(1'b1, {2'd3, 4'd4}, 64'hA5A5_5A5A_0F0F_F0F0, 8'hFF, st);
    sleep_req_i = 4'b1000;
    do_req(1'b0, {2'd3, 4'd4}, '0, '0, st);
    check_eq("sleep_rd_accept", 64'(st), 64'd0);
    @(negedge clk_i);
    #1;
    check_eq("sleep_rd_valid", 64'(rsp_valid_o), 64'd1);
    check_eq("sleep_rd_awake", 64'(bank_awake_o[3]), 64'd1);
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    check_eq("sleep_rd_after", 64'(bank_awake_o[3]), 64'd0);
    sleep_req_i = 4'b0000;

    // Reset during WAKING of bank 1 with a bank 0 read in flight.
    sleep_req_i = 4'b0010;
    repeat (2) @(negedge clk_i);
    do_req(1'b1, {2'd0, 4'd0}, 64'h7777_0000_7777_0000, 8'hFF, st);
    sleep_req_i = 4'b0000;
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_addr_i  = {2'd1, 4'd0};
    #1;
    check_eq("wake_req_stall", 64'(req_ready_o), 64'd0);
    @(negedge clk_i);
    req_addr_i = {2'd0, 4'd0};
    #1;
    check_eq("rst_rd_ready", 64'(req_ready_o), 64'd1);
    check_eq("rst_waking", 64'(bank_awake_o[1]), 64'd0);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    #1;
    check_eq("rst_mid_valid", 64'(rsp_valid_o), 64'd0);
    check_eq("rst_mid_awake", 64'(bank_awake_o), 64'hF);
    check_eq("rst_mid_rdata", rsp_rdata_o, 64'd0);
`ifdef SPM_BANKED_PERF_CNT_EN
    check_eq("rst_mid_perf_access", 64'(perf_access), 64'd0);
    check_eq("rst_mid_perf_stall", 64'(perf_stall), 64'd0);
`endif
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (6) @(negedge clk_i);

    do_req(1'b1, {2'd2, 4'd1}, 64'hBEEF_0000_1234_ABCD, 8'hFF, st);
    do_req(1'b0, {2'd2, 4'd1}, '0, '0, st);
    repeat (5) @(negedge clk_i);
    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
